mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbitrates the single memory bus between the data cache, the instruction-cache demand fetch and the instruction prefetcher. Forwards the winning request to memory and returns the memory's acceptance tag only to the winner. Tells the losing instruction-side requesters to give way. Records which requester owns each outstanding 4-bit memory tag, so returning data is delivered only to that owner.

## Interface
- `STARVE_LIMIT`, default 4: consecutive cycles the prefetcher may lose to the icache before it is forced to win.
- `clock` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `dcache2mem_command` input 2: BUS_NONE, BUS_LOAD or BUS_STORE.
- `dcache2mem_addr` input `XLEN`: data-side address.
- `dcache2mem_data` input 64: store data.
- `icache2mem_command` input 2: BUS_NONE or BUS_LOAD.
- `icache2mem_addr` input `XLEN`: demand-fetch address.
- `pref2mem_command` input 2: BUS_NONE or BUS_LOAD.
- `pref2mem_addr` input `XLEN`: prefetch address.
- `mem2proc_response` input 4: acceptance tag; 0 means rejected.
- `mem2proc_tag` input 4: tag of the completing transaction; 0 means none.
- `mem2proc_data` input 64: data for `mem2proc_tag`.
- `proc2mem_command` output 2: winning command.
- `proc2mem_addr` output `XLEN`: winning address.
- `proc2mem_data` output 64: store data, or 0 when the winner is not a store.
- `mem2dcache_response`, `mem2icache_response`, `mem2pref_response` output 4 each: `mem2proc_response` for the winner; 0 for all others.
- `icache_give_way`, `pref_give_way` output 1 each: requester was active but lost arbitration this cycle.
- `mem2dcache_tag`, `mem2icache_tag`, `mem2pref_tag` output 4 each: `mem2proc_tag` routed to its recorded owner; 0 for all others.
- `mem2cache_data` output 64: `mem2proc_data` broadcast to all requesters.

## Operation
- A requester is active when its command is not BUS_NONE.
- Normal priority is dcache > icache > prefetch.
- Starvation override:
  - `starve_cnt` (3 bits) increments when the prefetcher is active, the icache wins, and dcache is idle.
  - When `starve_cnt == STARVE_LIMIT` and dcache is idle, the prefetcher wins over the icache.
  - `starve_cnt` clears on any prefetch grant, and whenever the prefetcher is idle.
  - The dcache is never overridden.
- Owner table: 15 entries, indexed by tags 1..15. Each entry holds an owner value: NONE, DCACHE_LD, DCACHE_ST, ICACHE or PREF.
- Grant acceptance: when the winner gets a nonzero `mem2proc_response`, the entry at that tag is set to the winner's owner value. A dcache store records DCACHE_ST.
- Rejection: when the winner gets a 0 response, no table write occurs. The give_way flags are unaffected, since they indicate arbitration loss only.
- Completion: when `mem2proc_tag` is nonzero, that entry is looked up and the tag is routed to the matching owner output, then the entry is cleared to NONE.
  - DCACHE_ST completions are routed to `mem2dcache_tag`.
  - NONE completions are dropped and every tag output is 0.
- Same tag completing and re-granted in one cycle: the clear happens first and the set wins. The entry holds the new owner.

## Timing
- The request path is combinational. Command, address, data, response routing and give_way all resolve in the same cycle.
- The owner table and `starve_cnt` update on the rising clock edge.
- Completion routing is combinational from the table contents before that edge.
- Reset values:
  - Table is all NONE and `starve_cnt` is 0.
  - With all requesters idle, every output is 0, including `proc2mem_command = BUS_NONE`.
- Reset mid-operation: the table is cleared. Tags completing afterwards are dropped with no tag output asserted.
- Latency from grant to data delivery is whatever memory takes. The arbiter adds 0 cycles.

## Structure
- Owner enum (NONE, DCACHE_LD, DCACHE_ST, ICACHE, PREF) belongs in `sys_defs`, alongside BUS_NONE/BUS_LOAD/BUS_STORE and `XLEN`.
- Sub-module `mem_tag_owner_table`: the 15-entry table, with a write port and a read-then-clear port, enforcing the set-wins rule. Everything else stays in the top module.

## Test plan
- dcache LOAD at 0x100 and icache LOAD at 0x200 in the same cycle, response 3 → `proc2mem_addr = 0x100`, `mem2dcache_response = 3`, `icache_give_way = 1`, `mem2icache_response = 0`. Later `mem2proc_tag = 3` → `mem2dcache_tag = 3` only.
- icache and prefetch both active for 5 cycles, dcache idle, `STARVE_LIMIT = 4`, responses 1..5 → icache wins cycles 0–3 and the prefetcher wins cycle 4 with `pref_give_way = 0` and `icache_give_way = 1`. `starve_cnt` returns to 0.
- prefetch wins alone and gets response 0 → no table write, `mem2pref_response = 0`. A later `mem2proc_tag = 0` routes nothing.
- tag 7 is owned by ICACHE; in one cycle `mem2proc_tag = 7` and a prefetch grant gets response 7 → `mem2icache_tag = 7`, and the entry then holds PREF. The next `mem2proc_tag = 7` routes to `mem2pref_tag`.
- dcache STORE with data 0xDEADBEEF, response 2 → `proc2mem_data` carries it. The completion of tag 2 routes to `mem2dcache_tag`.
- grant tag 5 to the icache, assert reset for one cycle, then `mem2proc_tag = 5` → all tag outputs are 0.

Source files
------------

// File: rtl/sys_defs.sv
// Shared bus-level definitions: command encodings, tag ownership and address width.
package sys_defs;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  typedef enum logic [2:0] {
    OWNER_NONE      = 3'd0,
    OWNER_DCACHE_LD = 3'd1,
    OWNER_DCACHE_ST = 3'd2,
    OWNER_ICACHE    = 3'd3,
    OWNER_PREF      = 3'd4
  } owner_e;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_DCACHE = 2'd1,
    GNT_ICACHE = 2'd2,
    GNT_PREF   = 2'd3
  } grant_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester, memory and return-path signals of the shared memory bus.
interface mem_bus_arbiter_if;
  import sys_defs::*;

  bus_command_e           dcache2mem_command;
  logic [XLEN-1:0]        dcache2mem_addr;
  logic [63:0]            dcache2mem_data;
  bus_command_e           icache2mem_command;
  logic [XLEN-1:0]        icache2mem_addr;
  bus_command_e           pref2mem_command;
  logic [XLEN-1:0]        pref2mem_addr;
  logic [3:0]             mem2proc_response;
  logic [3:0]             mem2proc_tag;
  logic [63:0]            mem2proc_data;

  bus_command_e           proc2mem_command;
  logic [XLEN-1:0]        proc2mem_addr;
  logic [63:0]            proc2mem_data;
  logic [3:0]             mem2dcache_response;
  logic [3:0]             mem2icache_response;
  logic [3:0]             mem2pref_response;
  logic                   icache_give_way;
  logic                   pref_give_way;
  logic [3:0]             mem2dcache_tag;
  logic [3:0]             mem2icache_tag;
  logic [3:0]             mem2pref_tag;
  logic [63:0]            mem2cache_data;

  // Requesters and memory drive the bus; the arbiter is the slave.
  modport master (
    output dcache2mem_command, dcache2mem_addr, dcache2mem_data,
           icache2mem_command, icache2mem_addr,
           pref2mem_command, pref2mem_addr,
           mem2proc_response, mem2proc_tag, mem2proc_data,
    input  proc2mem_command, proc2mem_addr, proc2mem_data,
           mem2dcache_response, mem2icache_response, mem2pref_response,
           icache_give_way, pref_give_way,
           mem2dcache_tag, mem2icache_tag, mem2pref_tag, mem2cache_data
  );

  modport slave (
    input  dcache2mem_command, dcache2mem_addr, dcache2mem_data,
           icache2mem_command, icache2mem_addr,
           pref2mem_command, pref2mem_addr,
           mem2proc_response, mem2proc_tag, mem2proc_data,
    output proc2mem_command, proc2mem_addr, proc2mem_data,
           mem2dcache_response, mem2icache_response, mem2pref_response,
           icache_give_way, pref_give_way,
           mem2dcache_tag, mem2icache_tag, mem2pref_tag, mem2cache_data
  );
endinterface

// File: rtl/mem_bus_arbiter_table.sv
// Owner of each outstanding memory tag (1..15); a same-cycle set overrides the completion clear.
module mem_tag_owner_table
  import sys_defs::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en_i,
  input  logic [3:0] wr_tag_i,
  input  owner_e     wr_owner_i,
  input  logic [3:0] rd_tag_i,
  output owner_e     rd_owner_o
);

  owner_e owner_q [1:15];
  owner_e owner_d [1:15];

  // Tag 0 never matches an entry, so it reads NONE and clears nothing.
  always_comb begin
    rd_owner_o = OWNER_NONE;
    for (int unsigned i = 1; i <= 15; i++) begin
      if (rd_tag_i == 4'(i)) rd_owner_o = owner_q[i];
    end
  end

  always_comb begin
    owner_d = owner_q;
    for (int unsigned i = 1; i <= 15; i++) begin
      if (rd_tag_i == 4'(i)) owner_d[i] = OWNER_NONE;
      if (wr_en_i && wr_tag_i == 4'(i)) owner_d[i] = wr_owner_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q <= '{default: OWNER_NONE};
    end else begin
      owner_q <= owner_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between dcache, icache demand fetch and prefetcher; routes tags to owners.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  mem_bus_arbiter_if.slave  bus
);

  logic       d_act, i_act, p_act, pref_force;
  grant_e     gnt;
  logic [2:0] starve_cnt_q, starve_cnt_d;
  logic       tbl_wr_en;
  owner_e     tbl_wr_owner;
  owner_e     cpl_owner;

  assign d_act      = bus.dcache2mem_command != BUS_NONE;
  assign i_act      = bus.icache2mem_command != BUS_NONE;
  assign p_act      = bus.pref2mem_command   != BUS_NONE;
  assign pref_force = p_act && !d_act && (starve_cnt_q == 3'(STARVE_LIMIT));

  always_comb begin
    gnt = GNT_NONE;
    if (d_act)                    gnt = GNT_DCACHE;
    else if (i_act && !pref_force) gnt = GNT_ICACHE;
    else if (p_act)               gnt = GNT_PREF;
  end

  // Counter holds while the dcache owns the bus so the override resumes afterwards.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!p_act || gnt == GNT_PREF) starve_cnt_d = '0;
    else if (gnt == GNT_ICACHE)    starve_cnt_d = starve_cnt_q + 3'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end

  always_comb begin
    bus.proc2mem_command    = BUS_NONE;
    bus.proc2mem_addr       = '0;
    bus.proc2mem_data       = '0;
    bus.mem2dcache_response = '0;
    bus.mem2icache_response = '0;
    bus.mem2pref_response   = '0;
    tbl_wr_owner            = OWNER_NONE;
    unique case (gnt)
      GNT_DCACHE: begin
        bus.proc2mem_command    = bus.dcache2mem_command;
        bus.proc2mem_addr       = bus.dcache2mem_addr;
        bus.mem2dcache_response = bus.mem2proc_response;
        if (bus.dcache2mem_command == BUS_STORE) begin
          bus.proc2mem_data = bus.dcache2mem_data;
          tbl_wr_owner      = OWNER_DCACHE_ST;
        end else begin
          tbl_wr_owner      = OWNER_DCACHE_LD;
        end
      end
      GNT_ICACHE: begin
        bus.proc2mem_command    = bus.icache2mem_command;
        bus.proc2mem_addr       = bus.icache2mem_addr;
        bus.mem2icache_response = bus.mem2proc_response;
        tbl_wr_owner            = OWNER_ICACHE;
      end
      GNT_PREF: begin
        bus.proc2mem_command  = bus.pref2mem_command;
        bus.proc2mem_addr     = bus.pref2mem_addr;
        bus.mem2pref_response = bus.mem2proc_response;
        tbl_wr_owner          = OWNER_PREF;
      end
      default: ;
    endcase
  end

  assign bus.icache_give_way = i_act && gnt != GNT_ICACHE;
  assign bus.pref_give_way   = p_act && gnt != GNT_PREF;
  assign tbl_wr_en           = gnt != GNT_NONE && bus.mem2proc_response != '0;

  mem_tag_owner_table u_table (
    .clock      (clock),
    .reset      (reset),
    .wr_en_i    (tbl_wr_en),
    .wr_tag_i   (bus.mem2proc_response),
    .wr_owner_i (tbl_wr_owner),
    .rd_tag_i   (bus.mem2proc_tag),
    .rd_owner_o (cpl_owner)
  );

  always_comb begin
    bus.mem2dcache_tag = '0;
    bus.mem2icache_tag = '0;
    bus.mem2pref_tag   = '0;
    unique case (cpl_owner)
      OWNER_DCACHE_LD, OWNER_DCACHE_ST: bus.mem2dcache_tag = bus.mem2proc_tag;
      OWNER_ICACHE:                     bus.mem2icache_tag = bus.mem2proc_tag;
      OWNER_PREF:                       bus.mem2pref_tag   = bus.mem2proc_tag;
      default: ;
    endcase
  end

  assign bus.mem2cache_data = bus.mem2proc_data;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed vectors for mem_bus_arbiter: priority, starvation override, tag ownership, reset.
module tb_mem_bus_arbiter;
  import sys_defs::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.dcache2mem_command = BUS_NONE;
    bus.dcache2mem_addr    = '0;
    bus.dcache2mem_data    = '0;
    bus.icache2mem_command = BUS_NONE;
    bus.icache2mem_addr    = '0;
    bus.pref2mem_command   = BUS_NONE;
    bus.pref2mem_addr      = '0;
    bus.mem2proc_response  = '0;
    bus.mem2proc_tag       = '0;
    bus.mem2proc_data      = '0;
  endtask

  task automatic check_tags(input string tag, input logic [3:0] d, input logic [3:0] i, input logic [3:0] p);
    check({tag, ".dtag"}, 64'(bus.mem2dcache_tag), 64'(d));
    check({tag, ".itag"}, 64'(bus.mem2icache_tag), 64'(i));
    check({tag, ".ptag"}, 64'(bus.mem2pref_tag),   64'(p));
  endtask

  task automatic check_resp(input string tag, input logic [3:0] d, input logic [3:0] i, input logic [3:0] p);
    check({tag, ".dresp"}, 64'(bus.mem2dcache_response), 64'(d));
    check({tag, ".iresp"}, 64'(bus.mem2icache_response), 64'(i));
    check({tag, ".presp"}, 64'(bus.mem2pref_response),   64'(p));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic next_vec();
    @(negedge clock);
    idle();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clock);
    #1;
    check("rst.cmd",  64'(bus.proc2mem_command), 64'(BUS_NONE));
    check("rst.addr", 64'(bus.proc2mem_addr), 64'd0);
    check("rst.data", bus.proc2mem_data, 64'd0);
    check("rst.igw",  64'(bus.icache_give_way), 64'd0);
    check("rst.pgw",  64'(bus.pref_give_way), 64'd0);
    check("rst.mdata", bus.mem2cache_data, 64'd0);
    check_resp("rst", 4'd0, 4'd0, 4'd0);
    check_tags("rst", 4'd0, 4'd0, 4'd0);
    @(negedge clock);
    reset = 1'b0;

    // dcache beats icache
    next_vec();
    bus.dcache2mem_command = BUS_LOAD;  bus.dcache2mem_addr = 32'h100;
    bus.dcache2mem_data    = 64'h55;
    bus.icache2mem_command = BUS_LOAD;  bus.icache2mem_addr = 32'h200;
    bus.mem2proc_response  = 4'd3;
    #1;
    check("p1.cmd",  64'(bus.proc2mem_command), 64'(BUS_LOAD));
    check("p1.addr", 64'(bus.proc2mem_addr), 64'h100);
    check("p1.data", bus.proc2mem_data, 64'd0);
    check("p1.igw",  64'(bus.icache_give_way), 64'd1);
    check("p1.pgw",  64'(bus.pref_give_way), 64'd0);
    check_resp("p1", 4'd3, 4'd0, 4'd0);
    next_vec();
    bus.mem2proc_tag = 4'd3;  bus.mem2proc_data = 64'h1234_5678_9ABC_DEF0;
    #1;
    check_tags("p1cpl", 4'd3, 4'd0, 4'd0);
    check("p1cpl.mdata", bus.mem2cache_data, 64'h1234_5678_9ABC_DEF0);
    next_vec();
    bus.mem2proc_tag = 4'd3;
    #1;
    check_tags("p1clr", 4'd0, 4'd0, 4'd0);

    // icache vs prefetch: prefetch forced on the 5th cycle
    for (int c = 0; c < 6; c++) begin
      next_vec();
      bus.icache2mem_command = BUS_LOAD;  bus.icache2mem_addr = 32'h300;
      bus.pref2mem_command   = BUS_LOAD;  bus.pref2mem_addr   = 32'h400;
      bus.mem2proc_response  = (c < 5) ? 4'(c + 1) : 4'd0;
      #1;
      if (c == 4) begin
        check("st.addr4", 64'(bus.proc2mem_addr), 64'h400);
        check("st.igw4",  64'(bus.icache_give_way), 64'd1);
        check("st.pgw4",  64'(bus.pref_give_way), 64'd0);
        check_resp("st4", 4'd0, 4'd0, 4'd5);
      end else begin
        check($sformatf("st.addr%0d", c), 64'(bus.proc2mem_addr), 64'h300);
        check($sformatf("st.igw%0d", c),  64'(bus.icache_give_way), 64'd0);
        check($sformatf("st.pgw%0d", c),  64'(bus.pref_give_way), 64'd1);
        check($sformatf("st.iresp%0d", c), 64'(bus.mem2icache_response), 64'(bus.mem2proc_response));
        check($sformatf("st.presp%0d", c), 64'(bus.mem2pref_response), 64'd0);
      end
    end
    next_vec();
    bus.mem2proc_tag = 4'd5;
    #1;
    check_tags("st.cpl5", 4'd0, 4'd0, 4'd5);
    next_vec();
    bus.mem2proc_tag = 4'd1;
    #1;
    check_tags("st.cpl1", 4'd0, 4'd1, 4'd0);

    // prefetch alone, rejected
    next_vec();
    bus.pref2mem_command = BUS_LOAD;  bus.pref2mem_addr = 32'h480;
    #1;
    check("rej.cmd",  64'(bus.proc2mem_command), 64'(BUS_LOAD));
    check("rej.addr", 64'(bus.proc2mem_addr), 64'h480);
    check("rej.pgw",  64'(bus.pref_give_way), 64'd0);
    check_resp("rej", 4'd0, 4'd0, 4'd0);
    next_vec();
    #1;
    check_tags("rej.tag0", 4'd0, 4'd0, 4'd0);
    next_vec();
    bus.mem2proc_tag = 4'd9;
    #1;
    check_tags("rej.tag9", 4'd0, 4'd0, 4'd0);

    // tag 7 completes and is re-granted in the same cycle
    next_vec();
    bus.icache2mem_command = BUS_LOAD;  bus.icache2mem_addr = 32'h700;
    bus.mem2proc_response  = 4'd7;
    #1;
    check_resp("t7.grant", 4'd0, 4'd7, 4'd0);
    next_vec();
    bus.pref2mem_command  = BUS_LOAD;  bus.pref2mem_addr = 32'h740;
    bus.mem2proc_response = 4'd7;      bus.mem2proc_tag  = 4'd7;
    #1;
    check_tags("t7.same", 4'd0, 4'd7, 4'd0);
    check_resp("t7.same", 4'd0, 4'd0, 4'd7);
    next_vec();
    bus.mem2proc_tag = 4'd7;
    #1;
    check_tags("t7.pref", 4'd0, 4'd0, 4'd7);
    next_vec();
    bus.mem2proc_tag = 4'd7;
    #1;
    check_tags("t7.clr", 4'd0, 4'd0, 4'd0);

    // dcache store
    next_vec();
    bus.dcache2mem_command = BUS_STORE;  bus.dcache2mem_addr = 32'h500;
    bus.dcache2mem_data    = 64'hDEAD_BEEF;
    bus.pref2mem_command   = BUS_LOAD;   bus.pref2mem_addr   = 32'h540;
    bus.mem2proc_response  = 4'd2;
    #1;
    check("st.cmd",  64'(bus.proc2mem_command), 64'(BUS_STORE));
    check("st.data", bus.proc2mem_data, 64'hDEAD_BEEF);
    check("st.pgw",  64'(bus.pref_give_way), 64'd1);
    check_resp("store", 4'd2, 4'd0, 4'd0);
    next_vec();
    bus.mem2proc_tag = 4'd2;
    #1;
    check_tags("store.cpl", 4'd2, 4'd0, 4'd0);

    // reset clears the owner table
    next_vec();
    bus.icache2mem_command = BUS_LOAD;  bus.icache2mem_addr = 32'h600;
    bus.mem2proc_response  = 4'd5;
    #1;
    check_resp("rst5.grant", 4'd0, 4'd5, 4'd0);
    next_vec();
    reset = 1'b1;
    next_vec();
    reset = 1'b0;
    bus.mem2proc_tag = 4'd5;
    #1;
    check_tags("rst5.cpl", 4'd0, 4'd0, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
